// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - digit-serial signed/unsigned magnitude comparator
//
// Compares two WIDTH-bit operands MSB digit first, DIGIT bits per clock,
// behind a start/busy/done handshake.
//
// Parameters:
//   WIDTH      operand width in bits (integer multiple of DIGIT)
//   DIGIT      bits compared per clock
//   EARLY_EXIT 1 = finish on the first differing digit, 0 = always scan every digit
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled only while idle
//   signed_mode  1 = two's-complement compare, captured with start
//   a, b         operands, captured with start
//   busy         high while a comparison is in progress
//   done         one-cycle pulse when y2/y1/y0 become valid
//   y2, y1, y0   a > b, a == b, a < b (held until the next accepted start)
module serial_magnitude_comparator #(
    parameter int WIDTH      = 4,
    parameter int DIGIT      = 1,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             y2,
    output logic             y1,
    output logic             y0
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);
    localparam logic [KW-1:0]    K_LAST   = KW'(NDIG - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [KW-1:0]    k;
    logic             gt_r;
    logic             lt_r;

    // Operands are shifted left each cycle, so the digit under test is
    // always the top DIGIT bits of the working registers.
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic             resolved;
    logic             gt_n;
    logic             lt_n;
    logic             finish;

    always_comb begin
        a_dig    = a_r[WIDTH-1 -: DIGIT];
        b_dig    = b_r[WIDTH-1 -: DIGIT];
        resolved = gt_r | lt_r;
        // Only the first differing digit may decide the result.
        gt_n     = gt_r | (!resolved && (a_dig > b_dig));
        lt_n     = lt_r | (!resolved && (a_dig < b_dig));
        finish   = (k == K_LAST) || ((EARLY_EXIT != 0) && (gt_n || lt_n));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            k     <= '0;
            gt_r  <= 1'b0;
            lt_r  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            y2    <= 1'b0;
            y1    <= 1'b0;
            y0    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Flipping the sign bit of both operands maps two's
                        // complement order onto unsigned order.
                        a_r   <= signed_mode ? (a ^ SIGN_BIT) : a;
                        b_r   <= signed_mode ? (b ^ SIGN_BIT) : b;
                        k     <= '0;
                        gt_r  <= 1'b0;
                        lt_r  <= 1'b0;
                        busy  <= 1'b1;
                        y2    <= 1'b0;
                        y1    <= 1'b0;
                        y0    <= 1'b0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    a_r <= a_r << DIGIT;
                    b_r <= b_r << DIGIT;
                    k   <= k + KW'(1);
                    if (finish) begin
                        y2    <= gt_n;
                        y0    <= lt_n;
                        y1    <= !(gt_n || lt_n);
                        gt_r  <= 1'b0;
                        lt_r  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        gt_r <= gt_n;
                        lt_r <= lt_n;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - self-checking bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;

    // Instances: 0 = W4/D1/early, 1 = W4/D1/full, 2 = W8/D2/early, 3 = W8/D2/full
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i [4];
    logic       sm_i    [4];
    logic [7:0] a_i     [4];
    logic [7:0] b_i     [4];
    logic       busy_o  [4];
    logic       done_o  [4];
    logic       y2_o    [4];
    logic       y1_o    [4];
    logic       y0_o    [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(4), .DIGIT(1), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst(rst), .start(start_i[0]), .signed_mode(sm_i[0]),
        .a(a_i[0][3:0]), .b(b_i[0][3:0]), .busy(busy_o[0]), .done(done_o[0]),
        .y2(y2_o[0]), .y1(y1_o[0]), .y0(y0_o[0]));
    serial_magnitude_comparator #(.WIDTH(4), .DIGIT(1), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst(rst), .start(start_i[1]), .signed_mode(sm_i[1]),
        .a(a_i[1][3:0]), .b(b_i[1][3:0]), .busy(busy_o[1]), .done(done_o[1]),
        .y2(y2_o[1]), .y1(y1_o[1]), .y0(y0_o[1]));
    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst(rst), .start(start_i[2]), .signed_mode(sm_i[2]),
        .a(a_i[2]), .b(b_i[2]), .busy(busy_o[2]), .done(done_o[2]),
        .y2(y2_o[2]), .y1(y1_o[2]), .y0(y0_o[2]));
    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u3 (
        .clk(clk), .rst(rst), .start(start_i[3]), .signed_mode(sm_i[3]),
        .a(a_i[3]), .b(b_i[3]), .busy(busy_o[3]), .done(done_o[3]),
        .y2(y2_o[3]), .y1(y1_o[3]), .y0(y0_o[3]));

    typedef struct {
        int         inst;
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic [2:0] y;
        int         lat;
    } vec_t;

    function automatic logic [2:0] yv(input int i);
        return {y2_o[i], y1_o[i], y0_o[i]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: integer compare of the (optionally sign-interpreted) operands;
    // early-exit latency is set by the most significant differing bit's digit.
    function automatic void model(input int i, input logic [7:0] av, input logic [7:0] bv,
                                  input logic sm, output logic [2:0] y, output int lat);
        int w    = (i < 2) ? 4 : 8;
        int d    = (i < 2) ? 1 : 2;
        bit ee   = (i == 0) || (i == 2);
        int mask = (1 << w) - 1;
        int ia   = int'(av) & mask;
        int ib   = int'(bv) & mask;
        int x    = ia ^ ib;
        int p    = -1;
        if (sm) begin
            if (ia >= (1 << (w - 1))) ia -= (1 << w);
            if (ib >= (1 << (w - 1))) ib -= (1 << w);
        end
        y   = (ia > ib) ? 3'b100 : (ia == ib) ? 3'b010 : 3'b001;
        lat = w / d;
        for (int j = 0; j < w; j++) if (x[j]) p = j;
        if (ee && p >= 0) lat = (w - 1 - p) / d + 1;
    endfunction

    // Leaves the bench at the negedge just after the start-sampling edge.
    task automatic issue(input int i, input logic [7:0] av, input logic [7:0] bv, input logic sm);
        a_i[i]     = av;
        b_i[i]     = bv;
        sm_i[i]    = sm;
        start_i[i] = 1'b1;
        step();
        start_i[i] = 1'b0;
    endtask

    // n0 = clock edges already taken since the start-sampling edge.
    task automatic wait_done(input int i, input int n0, input logic [2:0] ey, input int elat,
                             input bit hold, input string nm);
        int n     = n0;
        bit busy_ok = 1'b1;
        while (!done_o[i] && n < 40) begin
            if (busy_o[i] !== 1'b1 || yv(i) !== 3'b000) busy_ok = 1'b0;
            step();
            n++;
        end
        check({nm, "_done_seen"}, done_o[i], 1'b1);
        check({nm, "_busy_phase"}, busy_ok, 1'b1);
        check({nm, "_latency"}, n, elat);
        check({nm, "_busy_at_done"}, busy_o[i], 1'b0);
        check({nm, "_result"}, yv(i), ey);
        if (hold) begin
            step();
            check({nm, "_done_pulse_width"}, done_o[i], 1'b0);
            check({nm, "_result_held"}, yv(i), ey);
        end
    endtask

    vec_t vecs [9];

    initial begin
        logic [2:0] ey;
        int         el;
        int         ii;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        bit         no_done;

        vecs[0] = '{0, 8'h08, 8'h0A, 1'b0, 3'b001, 3};
        vecs[1] = '{0, 8'h07, 8'h07, 1'b0, 3'b010, 4};
        vecs[2] = '{0, 8'h04, 8'h0B, 1'b0, 3'b001, 1};
        vecs[3] = '{0, 8'h04, 8'h0B, 1'b1, 3'b100, 1};
        vecs[4] = '{0, 8'h0F, 8'h0C, 1'b1, 3'b100, 3};
        vecs[5] = '{1, 8'h03, 8'h0F, 1'b0, 3'b001, 4};
        vecs[6] = '{1, 8'h05, 8'h05, 1'b1, 3'b010, 4};
        vecs[7] = '{2, 8'h3C, 8'h3D, 1'b0, 3'b001, 4};
        vecs[8] = '{2, 8'h80, 8'h7F, 1'b1, 3'b001, 1};

        for (int i = 0; i < 4; i++) begin
            start_i[i] = 1'b0;
            sm_i[i]    = 1'b0;
            a_i[i]     = 8'h00;
            b_i[i]     = 8'h00;
        end
        rst = 1'b1;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_busy%0d", i), busy_o[i], 1'b0);
            check($sformatf("reset_done%0d", i), done_o[i], 1'b0);
            check($sformatf("reset_y%0d", i), yv(i), 3'b000);
        end
        rst = 1'b0;
        step();

        for (int v = 0; v < 9; v++) begin
            issue(vecs[v].inst, vecs[v].a, vecs[v].b, vecs[v].sm);
            wait_done(vecs[v].inst, 0, vecs[v].y, vecs[v].lat, 1'b1, $sformatf("vec%0d", v));
        end

        // Start while busy is ignored.
        issue(1, 8'h03, 8'h0F, 1'b0);
        step();
        a_i[1]     = 8'h00;
        b_i[1]     = 8'h00;
        start_i[1] = 1'b1;
        step();
        start_i[1] = 1'b0;
        wait_done(1, 2, 3'b001, 4, 1'b1, "start_while_busy");

        // Reset mid-scan aborts without a done pulse.
        issue(2, 8'h3C, 8'h3D, 1'b0);
        step();
        rst = 1'b1;
        step();
        check("abort_busy", busy_o[2], 1'b0);
        check("abort_done", done_o[2], 1'b0);
        check("abort_y", yv(2), 3'b000);
        rst     = 1'b0;
        no_done = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (done_o[2] !== 1'b0 || busy_o[2] !== 1'b0) no_done = 1'b0;
        end
        check("abort_no_done_after", no_done, 1'b1);

        // Back-to-back: start asserted in the done cycle.
        issue(2, 8'h3C, 8'h3D, 1'b0);
        wait_done(2, 0, 3'b001, 4, 1'b0, "b2b_first");
        issue(2, 8'h40, 8'h20, 1'b0);
        check("b2b_cleared_y", yv(2), 3'b000);
        check("b2b_accepted_busy", busy_o[2], 1'b1);
        wait_done(2, 0, 3'b100, 1, 1'b1, "b2b_second");

        // Randomized operands against the reference model.
        for (int r = 0; r < 300; r++) begin
            ii = int'($urandom_range(0, 3));
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            rs = 1'($urandom);
            model(ii, ra, rb, rs, ey, el);
            issue(ii, ra, rb, rs);
            wait_done(ii, 0, ey, el, 1'b1, $sformatf("rand%0d_i%0d_%02h_%02h_s%0d", r, ii, ra, rb, rs));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
